// File: rtl/div_seq_pkg.sv
// Shared constants for the multi-cycle divide sequencer:
// FSM encodings and iteration counter sizing.
package div_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_PREP = 3'd1;
    localparam logic [STATE_W-1:0] S_CALC = 3'd2;
    localparam logic [STATE_W-1:0] S_FIX  = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE = 3'd4;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor magnitude, keep on no borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // The shifted partial remainder can reach 2*dvs-1, so it needs WIDTH+1 bits.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign borrow   = diff[WIDTH];
    assign rem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divide sequencer for EX; stalls the
// pipeline while iterating and pulses result_valid for one cycle.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stallreq_for_ex,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   part_rem;
    logic [WIDTH-1:0]   part_quo;
    logic [WIDTH-1:0]   dvs_mag;
    logic               neg_quo;
    logic               neg_rem;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign a_neg = is_signed & dividend[WIDTH-1];
    assign b_neg = is_signed & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (part_rem),
        .quo      (part_quo),
        .dvs      (dvs_mag),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign stallreq_for_ex = !flush
        && ((state == S_IDLE && start)
            || state == S_PREP
            || state == S_CALC
            || state == S_FIX);

    assign result_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            part_rem  <= '0;
            part_quo  <= '0;
            dvs_mag   <= '0;
            neg_quo   <= 1'b0;
            neg_rem   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_PREP;
                end
                S_PREP: begin
                    part_rem <= '0;
                    part_quo <= a_mag;
                    dvs_mag  <= b_mag;
                    neg_quo  <= a_neg ^ b_neg;
                    neg_rem  <= a_neg;
                    cnt      <= '0;
                    if (divisor == '0) begin
                        quotient  <= '1;
                        remainder <= dividend;
                        state     <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    part_rem <= rem_next;
                    part_quo <= quo_next;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == LAST) state <= S_FIX;
                end
                S_FIX: begin
                    quotient  <= neg_quo ? -part_quo : part_quo;
                    remainder <= neg_rem ? -part_rem : part_rem;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
